// File: rtl/mesh_traffic_gen_if.sv
// ----------------------------------------------------------------------------
// mesh_traffic_gen_if
//   Processing-element port between a mesh router and the traffic generator
//   that sits beside it.
//   Injection (toward router): pesi valid, pedi packet, peri router ready.
//   Ejection  (from router)  : peso valid, pedo packet, pero generator ready.
//   master : traffic-generator side.  slave : router side.
// ----------------------------------------------------------------------------
interface mesh_traffic_gen_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  pesi;
  logic [DATA_WIDTH-1:0] pedi;
  logic                  peri;
  logic                  peso;
  logic                  pero;
  logic [DATA_WIDTH-1:0] pedo;

  modport master (
    output pesi, pedi, pero,
    input  peri, peso, pedo
  );

  modport slave (
    input  pesi, pedi, pero,
    output peri, peso, pedo
  );
endinterface

// File: rtl/mesh_traffic_gen.sv
// ----------------------------------------------------------------------------
// mesh_traffic_gen
//   Per-node traffic generator and checker for an X x Y mesh. It builds
//   routed packets for fixed, round-robin or LFSR-random destinations, paces
//   them with a programmable gap, and counts and checks ejected packets.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   polarity          VC polarity copied into packet bit 63 when it is built
//   start             one-cycle pulse that starts a run (ignored while busy)
//   mode              0 fixed, 1 round-robin, 2 LFSR random, 3 as 0
//   dest_x, dest_y    fixed destination for mode 0
//   pkt_count, gap    packets per run / idle cycles between packets
//   pe                PE port toward the router (master modport)
//   busy, done        run in progress / run finished (held until next start)
//   tx_count, rx_count, err_count   saturating 16-bit counters
// ----------------------------------------------------------------------------
module mesh_traffic_gen #(
  parameter int          DATA_WIDTH      = 64,
  parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
  parameter int          MESH_X          = 2,
  parameter int          MESH_Y          = 2,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                polarity,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [3:0]          dest_x,
  input  logic [3:0]          dest_y,
  input  logic [15:0]         pkt_count,
  input  logic [7:0]          gap,
  mesh_traffic_gen_if.master  pe,
  output logic                busy,
  output logic                done,
  output logic [15:0]         tx_count,
  output logic [15:0]         rx_count,
  output logic [15:0]         err_count
);

  typedef enum logic [2:0] {S_IDLE, S_PICK, S_SEND, S_GAP, S_DONE} state_t;

  localparam logic [7:0] OWN_X = CURRENT_ADDRESS[15:8];
  localparam logic [7:0] OWN_Y = CURRENT_ADDRESS[7:0];
  localparam logic [3:0] X_MASK = 4'(MESH_X - 1);
  localparam logic [3:0] Y_MASK = 4'(MESH_Y - 1);

  state_t                state_q, state_d;
  logic [15:0]           remain_q, seq_q, lfsr_q;
  logic [7:0]            gap_len_q, gap_cnt_q;
  logic [3:0]            cur_x_q, cur_y_q;
  logic [DATA_WIDTH-1:0] pkt_q, pkt_d;
  logic [15:0]           tx_q, rx_q, err_q;
  logic                  pero_q;

  logic       start_take, xfer, pick_self, pick_err, rx_take, rx_bad, lfsr_fb;
  logic [3:0] sel_x, sel_y;
  logic [8:0] dx, dy, adx, ady;
  logic       unused_pedo;

  // Next node in x-major order (y runs fastest), wrapping at the mesh edge.
  function automatic logic [7:0] next_node(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] nx, ny;
    nx = x;
    ny = y + 4'd1;
    if (y == Y_MASK) begin
      ny = 4'd0;
      nx = (x == X_MASK) ? 4'd0 : x + 4'd1;
    end
    return {nx, ny};
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign start_take = start && (state_q == S_IDLE || state_q == S_DONE);
  assign xfer       = (state_q == S_SEND) && pe.peri;
  assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Destination selection and packet assembly for the PICK cycle.
  // NOTE: every always_comb output is given a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_x = dest_x;
    sel_y = dest_y;
    case (mode)
      2'd1: begin
        // The cursor only ever lands on self once, so one skip suffices.
        if ({4'b0, cur_x_q} == OWN_X && {4'b0, cur_y_q} == OWN_Y)
          {sel_x, sel_y} = next_node(cur_x_q, cur_y_q);
        else
          {sel_x, sel_y} = {cur_x_q, cur_y_q};
      end
      2'd2: begin
        sel_x = lfsr_q[3:0] & X_MASK;
        sel_y = lfsr_q[7:4] & Y_MASK;
      end
      default: ;
    endcase
    pick_self = ({4'b0, sel_x} == OWN_X) && ({4'b0, sel_y} == OWN_Y);

    dx  = {5'b0, sel_x} - {1'b0, OWN_X};
    dy  = {5'b0, sel_y} - {1'b0, OWN_Y};
    adx = dx[8] ? (~dx + 9'd1) : dx;
    ady = dy[8] ? (~dy + 9'd1) : dy;

    pkt_d = {polarity,
             !dx[8] && (dx != 9'd0),
             !dy[8] && (dy != 9'd0),
             5'b0, adx[3:0], ady[3:0],
             CURRENT_ADDRESS,
             4'b0, sel_x, 4'b0, sel_y,
             seq_q};
  end

  assign pick_err = (state_q == S_PICK) && pick_self && (mode != 2'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE:
        if (start) state_d = (pkt_count == 16'd0) ? S_DONE : S_PICK;
      S_PICK:
        if (!pick_self)          state_d = S_SEND;
        else if (mode != 2'd2)   state_d = S_DONE;   // random mode retries instead
      S_SEND:
        if (xfer) begin
          if (remain_q == 16'd1)       state_d = S_DONE;
          else if (gap_len_q == 8'd0)  state_d = S_PICK;
          else                         state_d = S_GAP;
        end
      S_GAP:
        if (gap_cnt_q == 8'd1) state_d = S_PICK;
      default: state_d = S_IDLE;
    endcase
  end

  // Receive path runs regardless of the FSM state.
  assign rx_take = pe.peso && pero_q;
  assign rx_bad  = rx_take && ((pe.pedo[31:16] != CURRENT_ADDRESS) ||
                               (pe.pedo[47:40] >= 8'(MESH_X)) ||
                               (pe.pedo[39:32] >= 8'(MESH_Y)));
  assign unused_pedo = ^{pe.pedo[DATA_WIDTH-1:48], pe.pedo[15:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      remain_q  <= '0;
      seq_q     <= '0;
      lfsr_q    <= SEED;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      pkt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      err_q     <= '0;
      pero_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pero_q  <= 1'b1;

      if (state_q == S_PICK) begin
        lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        if (mode == 2'd1) {cur_x_q, cur_y_q} <= next_node(sel_x, sel_y);
        if (!pick_self)   pkt_q <= pkt_d;
      end

      if (start_take) begin
        remain_q  <= pkt_count;
        gap_len_q <= gap;
        seq_q     <= '0;
        tx_q      <= '0;
      end else if (xfer) begin
        remain_q  <= remain_q - 16'd1;
        seq_q     <= seq_q + 16'd1;
        tx_q      <= sat_add(tx_q, 2'd1);
        gap_cnt_q <= gap_len_q;
      end else if (state_q == S_GAP) begin
        gap_cnt_q <= gap_cnt_q - 8'd1;
      end

      // A packet received while a start is captured lands after the clear.
      rx_q  <= sat_add(start_take ? 16'h0 : rx_q, {1'b0, rx_take});
      err_q <= sat_add(start_take ? 16'h0 : err_q, {1'b0, rx_bad} + {1'b0, pick_err});
    end
  end

  assign pe.pesi   = (state_q == S_SEND);
  assign pe.pedi   = pkt_q;
  assign pe.pero   = pero_q;
  assign busy      = (state_q == S_PICK) || (state_q == S_SEND) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign tx_count  = tx_q;
  assign rx_count  = rx_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_mesh_traffic_gen.sv
// ----------------------------------------------------------------------------
// tb_mesh_traffic_gen
//   dut_a : node 0x0000 for fixed-destination, back-pressure, receive and
//           reset scenarios.
//   dut_b : node 0x0100 for the round-robin destination sequence.
//   g_node: four nodes of a 2x2 mesh joined by an ideal one-cycle crossbar.
// ----------------------------------------------------------------------------
module tb_mesh_traffic_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   total = 0;
  int   bad   = 0;

  // ---------------- dut_a ----------------
  logic        a_pol, a_start, a_busy, a_done;
  logic [1:0]  a_mode;
  logic [3:0]  a_dx, a_dy;
  logic [15:0] a_cnt, a_tx, a_rx, a_err;
  logic [7:0]  a_gap;
  mesh_traffic_gen_if #(.DATA_WIDTH(64)) a_if ();

  mesh_traffic_gen #(.CURRENT_ADDRESS(16'h0000)) dut_a (
    .clk(clk), .reset(reset), .polarity(a_pol), .start(a_start), .mode(a_mode),
    .dest_x(a_dx), .dest_y(a_dy), .pkt_count(a_cnt), .gap(a_gap), .pe(a_if),
    .busy(a_busy), .done(a_done), .tx_count(a_tx), .rx_count(a_rx), .err_count(a_err)
  );

  // ---------------- dut_b ----------------
  logic        b_start, b_busy, b_done;
  logic [1:0]  b_mode;
  logic [15:0] b_cnt, b_tx, b_rx, b_err;
  logic [7:0]  b_gap;
  mesh_traffic_gen_if #(.DATA_WIDTH(64)) b_if ();

  mesh_traffic_gen #(.CURRENT_ADDRESS(16'h0100)) dut_b (
    .clk(clk), .reset(reset), .polarity(1'b0), .start(b_start), .mode(b_mode),
    .dest_x(4'd0), .dest_y(4'd0), .pkt_count(b_cnt), .gap(b_gap), .pe(b_if),
    .busy(b_busy), .done(b_done), .tx_count(b_tx), .rx_count(b_rx), .err_count(b_err)
  );

  // ---------------- 2x2 mesh ----------------
  logic        m_start;
  logic [3:0]  m_pesi, m_peri, m_peso, m_pero, m_busy, m_done;
  logic [63:0] m_pedi [4];
  logic [63:0] m_pedo [4];
  logic [15:0] m_tx [4];
  logic [15:0] m_rx [4];
  logic [15:0] m_err [4];
  logic [1:0]  rot;

  for (genvar i = 0; i < 4; i++) begin : g_node
    mesh_traffic_gen_if #(.DATA_WIDTH(64)) nif ();
    assign nif.peri  = m_peri[i];
    assign nif.peso  = m_peso[i];
    assign nif.pedo  = m_pedo[i];
    assign m_pesi[i] = nif.pesi;
    assign m_pedi[i] = nif.pedi;
    assign m_pero[i] = nif.pero;

    mesh_traffic_gen #(
      .CURRENT_ADDRESS(16'(((i / 2) * 256) + (i % 2))),
      .SEED(16'hACE1 + 16'(i * 7))
    ) u_gen (
      .clk(clk), .reset(reset), .polarity(1'b0), .start(m_start), .mode(2'd2),
      .dest_x(4'd0), .dest_y(4'd0), .pkt_count(16'd50), .gap(8'(i)), .pe(nif),
      .busy(m_busy[i]), .done(m_done[i]), .tx_count(m_tx[i]), .rx_count(m_rx[i]),
      .err_count(m_err[i])
    );
  end

  always @(posedge clk) begin
    if (reset) rot <= 2'd0;
    else       rot <= rot + 2'd1;
  end

  function automatic int dest_idx(input logic [63:0] p);
    return int'({p[24], p[16]});
  endfunction

  // Ideal crossbar: each destination accepts at most one sender per cycle,
  // with a rotating priority so no sender starves.
  always_comb begin
    int s;
    s      = 0;
    m_peri = '0;
    m_peso = '0;
    for (int d = 0; d < 4; d++) m_pedo[d] = '0;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        s = (k + int'(rot)) % 4;
        if (!m_peso[d] && m_pesi[s] && m_pero[d] && dest_idx(m_pedi[s]) == d) begin
          m_peso[d] = 1'b1;
          m_peri[s] = 1'b1;
          m_pedo[d] = m_pedi[s];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({a_if.pesi, a_if.pero, a_busy, a_done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {a_if.pesi, a_if.pero, a_busy, a_done});
    end
    total++;
    if (a_if.pedi !== 64'h0) begin
      bad++;
      $display("FAIL reset_pedi got=%h want=0", a_if.pedi);
    end
    total++;
    if ({a_tx, a_rx, a_err} !== 48'h0) begin
      bad++;
      $display("FAIL reset_counters got=%h want=0", {a_tx, a_rx, a_err});
    end
    total++;
    if ({b_if.pesi, b_busy, m_pesi, m_pero} !== 10'b0) begin
      bad++;
      $display("FAIL reset_others got=%b want=0", {b_if.pesi, b_busy, m_pesi, m_pero});
    end
    reset = 1'b0;
    tick();
    total++;
    if (a_if.pero !== 1'b1) begin
      bad++;
      $display("FAIL pero_after_reset got=%b want=1", a_if.pero);
    end
  endtask

  task automatic test_fixed();
    logic [63:0] want;
    int n;
    a_mode = 2'd0; a_dx = 4'd1; a_dy = 4'd1; a_cnt = 16'd3; a_gap = 8'd2;
    a_pol = 1'b0; a_if.peri = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    total++;
    if ({a_if.pesi, a_busy, a_done} !== 3'b010) begin
      bad++;
      $display("FAIL fixed_pick_flags got=%b want=010", {a_if.pesi, a_busy, a_done});
    end
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (a_if.pesi !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      total++;
      if (n !== ((p == 0) ? 1 : 3)) begin
        bad++;
        $display("FAIL fixed_spacing pkt=%0d got=%0d want=%0d", p, n, (p == 0) ? 1 : 3);
      end
      want = {1'b0, 2'b11, 5'b0, 8'h11, 16'h0000, 16'h0101, 16'(p)};
      total++;
      if (a_if.pedi !== want) begin
        bad++;
        $display("FAIL fixed_pedi pkt=%0d got=%h want=%h", p, a_if.pedi, want);
      end
      tick();
      total++;
      if (a_tx !== 16'(p + 1)) begin
        bad++;
        $display("FAIL fixed_tx pkt=%0d got=%0d want=%0d", p, a_tx, p + 1);
      end
    end
    total++;
    if ({a_if.pesi, a_busy, a_done} !== 3'b001) begin
      bad++;
      $display("FAIL fixed_done got=%b want=001", {a_if.pesi, a_busy, a_done});
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] want;
    int n;
    a_pol = 1'b1; a_if.peri = 1'b0;
    want = {1'b1, 2'b11, 5'b0, 8'h11, 16'h0000, 16'h0101, 16'h0000};
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    total++;
    if ({a_if.pesi, a_if.pedi} !== {1'b1, want}) begin
      bad++;
      $display("FAIL bp_launch got=%b/%h want=1/%h", a_if.pesi, a_if.pedi, want);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({a_if.pesi, a_if.pedi, a_tx} !== {1'b1, want, 16'd0}) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d want=1/%h/0", c, a_if.pesi, a_if.pedi, a_tx, want);
      end
    end
    a_if.peri = 1'b1;
    tick();
    total++;
    if ({a_if.pesi, a_tx} !== {1'b0, 16'd1}) begin
      bad++;
      $display("FAIL bp_release got=%b/%0d want=0/1", a_if.pesi, a_tx);
    end
    n = 0;
    while (a_done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if ({a_done, a_tx} !== {1'b1, 16'd3}) begin
      bad++;
      $display("FAIL bp_finish got=%b/%0d want=1/3", a_done, a_tx);
    end
  endtask

  task automatic test_round_robin();
    logic [63:0] want [4];
    logic [63:0] got [8];
    int ng;
    int n;
    want[0] = 64'h0010_0100_0000_0000;
    want[1] = 64'h2011_0100_0001_0001;
    want[2] = 64'h2001_0100_0101_0002;
    want[3] = 64'h0010_0100_0000_0003;
    b_mode = 2'd1; b_cnt = 16'd4; b_gap = 8'd0; b_if.peri = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    ng = 0;
    n  = 0;
    while (b_done !== 1'b1 && n < 40) begin
      if (b_if.pesi === 1'b1 && ng < 8) begin
        got[ng] = b_if.pedi;
        ng++;
      end
      tick();
      n++;
    end
    total++;
    if (ng !== 4 || b_tx !== 16'd4) begin
      bad++;
      $display("FAIL rr_count got=%0d/%0d want=4/4", ng, b_tx);
    end
    for (int i = 0; i < 4 && i < ng; i++) begin
      total++;
      if (got[i] !== want[i]) begin
        bad++;
        $display("FAIL rr_pkt idx=%0d got=%h want=%h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_rx_error();
    logic [15:0] src [4];
    logic [15:0] dst [4];
    logic [15:0] w_rx [4];
    logic [15:0] w_err [4];
    src = '{16'h0000, 16'h0101, 16'h0200, 16'h0002};
    dst = '{16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
    w_rx  = '{16'd1, 16'd2, 16'd3, 16'd4};
    w_err = '{16'd1, 16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 4; i++) begin
      a_if.pedo = {16'h0, src[i], dst[i], 16'h1234};
      a_if.peso = 1'b1;
      tick();
      a_if.peso = 1'b0;
      total++;
      if ({a_rx, a_err} !== {w_rx[i], w_err[i]}) begin
        bad++;
        $display("FAIL rx_check idx=%0d got=%0d/%0d want=%0d/%0d", i, a_rx, a_err, w_rx[i], w_err[i]);
      end
    end
    a_if.pedo = {16'h0, 16'h0101, 16'h0000, 16'h0};
    a_if.peso = 1'b1;
    tick();
    tick();
    tick();
    a_if.peso = 1'b0;
    total++;
    if ({a_rx, a_err} !== {16'd7, 16'd3}) begin
      bad++;
      $display("FAIL rx_back_to_back got=%0d/%0d want=7/3", a_rx, a_err);
    end
    // Start with zero packets while a packet arrives in the same cycle.
    a_cnt = 16'd0;
    a_start = 1'b1;
    a_if.peso = 1'b1;
    tick();
    a_start = 1'b0;
    a_if.peso = 1'b0;
    total++;
    if ({a_rx, a_err, a_tx, a_busy, a_done} !== {16'd1, 16'd0, 16'd0, 2'b01}) begin
      bad++;
      $display("FAIL zero_run_rx got=%0d/%0d/%0d/%b%b want=1/0/0/01", a_rx, a_err, a_tx, a_busy, a_done);
    end
    // Fixed destination equal to self aborts the run with one error.
    a_mode = 2'd0; a_dx = 4'd0; a_dy = 4'd0; a_cnt = 16'd2;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    total++;
    if ({a_if.pesi, a_done, a_err, a_tx} !== {2'b01, 16'd1, 16'd0}) begin
      bad++;
      $display("FAIL self_dest got=%b%b/%0d/%0d want=01/1/0", a_if.pesi, a_done, a_err, a_tx);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    a_mode = 2'd0; a_dx = 4'd1; a_dy = 4'd0; a_cnt = 16'd3; a_gap = 8'd0;
    a_if.peri = 1'b0;
    a_if.pedo = {16'h0, 16'h0101, 16'h0000, 16'h0};
    a_if.peso = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_if.peso = 1'b0;
    tick();
    total++;
    if ({a_if.pesi, a_busy, a_rx} !== {2'b11, 16'd1}) begin
      bad++;
      $display("FAIL midrun_send got=%b%b/%0d want=11/1", a_if.pesi, a_busy, a_rx);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({a_if.pesi, a_busy, a_done, a_tx, a_rx, a_err} !== {3'b000, 48'h0}) begin
      bad++;
      $display("FAIL midrun_reset got=%b%b%b/%0d/%0d/%0d want=000/0/0/0",
               a_if.pesi, a_busy, a_done, a_tx, a_rx, a_err);
    end
    tick();
    a_if.peri = 1'b1;
    a_cnt = 16'd2;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n = 0;
    while (a_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if ({a_done, a_tx, a_err} !== {1'b1, 16'd2, 16'd0}) begin
      bad++;
      $display("FAIL midrun_rerun got=%b/%0d/%0d want=1/2/0", a_done, a_tx, a_err);
    end
  endtask

  task automatic test_mesh();
    int n;
    int sum;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    n = 0;
    while (m_done !== 4'hF && n < 5000) begin
      tick();
      n++;
    end
    total++;
    if (m_done !== 4'hF) begin
      bad++;
      $display("FAIL mesh_timeout got=%b want=1111", m_done);
    end
    tick();
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      sum += int'(m_rx[i]);
      total++;
      if ({m_tx[i], m_err[i]} !== {16'd50, 16'd0}) begin
        bad++;
        $display("FAIL mesh_node idx=%0d got=%0d/%0d want=50/0", i, m_tx[i], m_err[i]);
      end
    end
    total++;
    if (sum !== 200) begin
      bad++;
      $display("FAIL mesh_rx_sum got=%0d want=200", sum);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_pol = 1'b0; a_start = 1'b0; a_mode = 2'd0; a_dx = 4'd0; a_dy = 4'd0;
    a_cnt = 16'd0; a_gap = 8'd0;
    a_if.peri = 1'b0; a_if.peso = 1'b0; a_if.pedo = '0;
    b_start = 1'b0; b_mode = 2'd0; b_cnt = 16'd0; b_gap = 8'd0;
    b_if.peri = 1'b0; b_if.peso = 1'b0; b_if.pedo = '0;
    m_start = 1'b0;

    test_reset();
    test_fixed();
    test_backpressure();
    test_round_robin();
    test_rx_error();
    test_reset_mid_run();
    test_mesh();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesh_traffic_gen.md
# mesh_traffic_gen

Synthesizable, parametrised per-node traffic generator and checker that attaches to a router's PE port (pesi/pedi/peri, peso/pero/pedo) in an X×Y mesh. It replaces hand-written packet injection: it builds correctly routed packets for fixed, round-robin or pseudo-random destinations, paces them with a programmable gap, and counts and checks every packet ejected to its node. One instance sits beside each router; mesh-level benches read only its counters.

## Interface
- DATA_WIDTH, 64, packet width; fixed packet layout below requires 64
- CURRENT_ADDRESS, 16'h0000, own node address {x[15:8], y[7:0]}
- MESH_X, 2, mesh columns; power of two, 2..16
- MESH_Y, 2, mesh rows; power of two, 2..16
- SEED, 16'hACE1, LFSR seed; must be nonzero
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- polarity  in  1  router VC polarity; copied into packet bit 63 at launch
- start  in  1  one-cycle pulse that begins a run; ignored while busy
- mode  in  2  0 fixed destination, 1 round-robin over all other nodes, 2 LFSR random, 3 treated as 0
- dest_x, dest_y  in  4 each  fixed destination used in mode 0
- pkt_count  in  16  packets per run; sampled on start
- gap  in  8  idle cycles between packets; sampled on start
- pesi  out  1  packet valid toward router
- pedi  out  DATA_WIDTH  packet toward router
- peri  in  1  router ready
- peso  in  1  ejected packet valid
- pero  out  1  ready to accept an ejected packet
- pedo  in  DATA_WIDTH  ejected packet
- busy  out  1  run in progress
- done  out  1  run finished; held until the next start or reset
- tx_count, rx_count, err_count  out  16 each  saturating counters

## Operation
- Packet layout: [63] vc = polarity, [62] east(1)/west(0), [61] north(1)/south(0), [60:56] 0, [55:52] |dx|, [51:48] |dy|, [47:32] CURRENT_ADDRESS, [31:16] destination address, [15:0] sequence number.
- dx = dest_x − own x, dy = dest_y − own y; a direction bit is 1 only when the delta is strictly positive. Destination equal to self is never launched.
- FSM states: IDLE, PICK, SEND, GAP, DONE.
- IDLE: on start, latch pkt_count and gap, clear tx/rx/err counters and sequence → PICK. If pkt_count = 0, go → DONE instead.
- PICK (one cycle): select destination. Mode 0 with self destination → DONE immediately, err_count += 1. Mode 1: next node in x-major order from a cursor starting at (0,0), skipping self, wrapping. Mode 2: x = LFSR[3:0] mod MESH_X, y = LFSR[7:4] mod MESH_Y; on self, advance the LFSR and stay in PICK. Build pedi → SEND.
- SEND: pesi = 1, pedi stable. A transfer occurs at an edge where pesi && peri. On transfer, tx_count += 1 and seq += 1 (16-bit wrap). When the last packet transfers → DONE; if gap = 0 → PICK; otherwise → GAP.
- GAP: count gap cycles, then → PICK.
- DONE: done = 1, busy = 0. start → re-run from IDLE semantics.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances once per PICK cycle.
- Receive path, independent of the FSM: pero = 1 whenever not in reset. On peso && pero, rx_count += 1. err_count += 1 if pedo[31:16] ≠ CURRENT_ADDRESS, or if the source x ≥ MESH_X or the source y ≥ MESH_Y.
- Counters saturate at 16'hFFFF.

## Timing
- Reset: pesi 0, pedi 0, pero 0, busy 0, done 0, all counters 0, LFSR = SEED, cursor = (0,0), FSM = IDLE. Reset mid-run aborts; pesi is 0 after that edge.
- start → first pesi two edges later (IDLE→PICK→SEND).
- With peri held high and gap = g, packets launch every g+2 cycles (SEND, g GAP cycles, PICK).
- pesi and pedi must not change while pesi && !peri.
- Receive path accepts one packet per cycle. A packet accepted in the same cycle a start is captured is counted after the clear.
- done rises the edge after the final transfer.

## Test plan
- 2×2 mesh, node 0x0000, mode 0, dest (1,1), pkt_count 3, gap 2, peri = 1 → three packets with bits [62:48] = 2'b11, 5'b0, 8'h11; payload 0x0101_0000/0001/0002; tx_count 3; done.
- Same setup with peri held low for 5 cycles → pesi stays 1 with pedi unchanged; transfer occurs on the first peri-high edge.
- Node 0x0100, mode 1, pkt_count 4 → destinations 0x0000, 0x0001, 0x0101, 0x0000; never 0x0100.
- Four instances in a 2×2 mesh, each in mode 2 with pkt_count 50 → the sum of rx_count equals 200 and every err_count is 0.
- Inject pedo with dest field 0xBEEF and peso = 1 → rx_count 1, err_count 1.
- Assert reset during SEND → pesi is 0 on the next edge; counters are 0 and busy is 0; a following start runs normally.
